uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 25 ++
 rtl/serial_fifo.sv | 70 +++++++
 rtl/uart_tx_fifo.sv | 134 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// ============================================================================
// Module   : uart_tx_fifo_pkg
// Purpose  : Shared FSM encoding and 8N1 frame constants for the UART transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_tx_fifo_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE  = 2'd0;
    localparam tx_state_t ST_START = 2'd1;
    localparam tx_state_t ST_DATA  = 2'd2;
    localparam tx_state_t ST_STOP  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/serial_fifo.sv
// ============================================================================
// Module   : serial_fifo
// Purpose  : Single-clock byte FIFO with registered occupancy; full push and empty pop are ignored.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [7:0]            data_i,
    output logic [7:0]            data_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int C_DEPTH = 2 ** DEPTH_LOG2;

    logic [7:0]            mem_q [C_DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    // Occupancy tops out at exactly 2**DEPTH_LOG2, so the count MSB alone means full.
    assign full_o  = count_q[DEPTH_LOG2];
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : FIFO-buffered 8N1 UART transmitter fed by a send/ready byte handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [7:0]                 IN_DATA,
    input  logic                       IN_SEND,
    output logic                       IN_READY,
    output logic                       OUT_SERIAL_TX,
    output logic                       OUT_IDLE,
    output logic [FIFO_DEPTH_LOG2:0]   OUT_COUNT
);

    localparam logic [15:0] C_BAUD_TERM = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  C_LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t                state_q, state_d;
    logic [15:0]              baud_q, baud_d;
    logic [2:0]               idx_q, idx_d;
    logic [7:0]               shift_q, shift_d;
    logic                     tx_q, tx_d;
    logic                     fifo_pop, fifo_full, fifo_empty, baud_term;
    logic [7:0]               fifo_head;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    serial_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (IN_SEND),
        .pop_i   (fifo_pop),
        .data_i  (IN_DATA),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign IN_READY      = !fifo_full;
    assign OUT_COUNT     = fifo_count;
    assign OUT_SERIAL_TX = tx_q;
    assign OUT_IDLE      = (state_q == ST_IDLE) && fifo_empty;
    assign baud_term     = (baud_q == C_BAUD_TERM);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    idx_d    = '0;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_term) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_term) begin
                    baud_d = '0;
                    idx_d  = idx_q + 1'b1;
                    if (idx_q == C_LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_term) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level is decoded from the next state so the register holds each bit glitch-free.
    always_comb begin
        tx_d = STOP_BIT;
        case (state_d)
            ST_START: tx_d = START_BIT;
            ST_DATA:  tx_d = shift_d[idx_d];
            default:  tx_d = STOP_BIT;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo against a frame-level queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int CB    = 434;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, send, ready, tx, idle;
    logic [7:0] data;
    logic [4:0] count;
    logic       rst_b, send_b, ready_b, tx_b, idle_b;
    logic [7:0] data_b;
    logic [4:0] count_b;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH_LOG2(4)) dut (
        .CLK(clk), .RESET(rst), .IN_DATA(data), .IN_SEND(send), .IN_READY(ready),
        .OUT_SERIAL_TX(tx), .OUT_IDLE(idle), .OUT_COUNT(count)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CB), .FIFO_DEPTH_LOG2(4)) dut_b (
        .CLK(clk), .RESET(rst_b), .IN_DATA(data_b), .IN_SEND(send_b), .IN_READY(ready_b),
        .OUT_SERIAL_TX(tx_b), .OUT_IDLE(idle_b), .OUT_COUNT(count_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference: queued bytes plus the position inside the frame currently on the wire.
    logic [7:0] mq[$];
    int         pos = -1;
    logic [7:0] cur = 8'h00;
    int         full_pop_hits = 0;

    // Independent line decoder.
    int         fpos = -1;
    logic [9:0] msh = '0;
    logic [7:0] dec[$];
    int         starts[$];
    logic       prev_tx = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic model_update(input logic s, input logic [7:0] d, input logic r);
        bit can_push;
        if (r) begin
            mq.delete();
            pos = -1;
            return;
        end
        can_push = (mq.size() < DEPTH);
        if (pos < 0) begin
            if (mq.size() > 0) begin
                cur = mq.pop_front();
                pos = 0;
            end
        end else begin
            pos++;
            if (pos == FRAME) pos = -1;
        end
        if (s && can_push) mq.push_back(d);
    endtask

    task automatic monitor(input logic r);
        if (r) begin
            fpos = -1;
        end else if (fpos < 0) begin
            if (prev_tx && !tx) begin
                fpos = 0;
                starts.push_back(cyc);
            end
        end else begin
            fpos++;
        end
        if (fpos >= 0 && (fpos % C) == C / 2) msh[fpos / C] = tx;
        if (fpos == FRAME - 1) begin
            dec.push_back(msh[8:1]);
            fpos = -1;
        end
        prev_tx = tx;
    endtask

    task automatic tick(input logic s, input logic [7:0] d, input logic r);
        bit fp;
        send = s;
        data = d;
        rst  = r;
        fp   = !r && s && (mq.size() == DEPTH) && (pos < 0);
        @(posedge clk);
        cyc++;
        model_update(s, d, r);
        #1;
        check_eq("count", 32'(count), 32'(mq.size()));
        check_eq("ready", 32'(ready), (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        check_eq("idle",  32'(idle),  (pos < 0 && mq.size() == 0) ? 32'd1 : 32'd0);
        check_eq("line",  32'(tx),    32'((pos < 0) ? 1'b1 : frame_bit(cur, pos / C)));
        if (fp) begin
            full_pop_hits++;
            check_eq("full_pop_count", 32'(count), 32'(DEPTH - 1));
        end
        monitor(r);
        send = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic idle_tick();
        tick(1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_byte(input logic [7:0] d);
        tick(1'b1, d, 1'b0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000 && !(pos < 0 && mq.size() == 0); i++) idle_tick();
        idle_tick();
        check_eq("drain_idle", 32'(idle), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_aa;
        rst = 1'b1; send = 1'b0; data = 8'h00;
        rst_b = 1'b1; send_b = 1'b0; data_b = 8'h00;

        tick(1'b0, 8'h00, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        rst_b = 1'b0;
        check_eq("rst_tx",    32'(tx),    32'd1);
        check_eq("rst_ready", 32'(ready), 32'd1);
        check_eq("rst_idle",  32'(idle),  32'd1);
        check_eq("rst_count", 32'(count), 32'd0);
        idle_tick();

        // Single byte: accepted in cycle 0, line low from cycle 2.
        dec.delete(); starts.delete();
        push_byte(8'h55);
        check_eq("lat_count",   32'(count), 32'd1);
        check_eq("lat_line_hi", 32'(tx),    32'd1);
        for (int t = 2; t <= 43; t++) begin
            idle_tick();
            if (t == 2)  check_eq("lat_start",   32'(tx),   32'd0);
            if (t == 6)  check_eq("bit0",        32'(tx),   32'd1);
            if (t == 10) check_eq("bit1",        32'(tx),   32'd0);
            if (t == 41) check_eq("stop_busy",   32'(idle), 32'd0);
            if (t == 43) check_eq("single_idle", 32'(idle), 32'd1);
        end
        check_eq("single_dec_n", 32'(dec.size()), 32'd1);
        if (dec.size() > 0) check_eq("single_dec", 32'(dec[0]), 32'h55);

        // Back-to-back frames.
        dec.delete(); starts.delete();
        push_byte(8'h1B);
        push_byte(8'h5B);
        for (int i = 0; i < 150 && dec.size() < 2; i++) idle_tick();
        check_eq("b2b_frames", 32'(dec.size()), 32'd2);
        if (starts.size() >= 2) check_eq("b2b_gap", 32'(starts[1] - starts[0]), 32'd41);
        if (dec.size() >= 2) begin
            check_eq("b2b_byte0", 32'(dec[0]), 32'h1B);
            check_eq("b2b_byte1", 32'(dec[1]), 32'h5B);
        end

        // Fill to 16, drop 0xAA, then hold IN_SEND across the IDLE pop at full.
        wait_idle();
        dec.delete();
        for (int i = 0; i < 17; i++) push_byte(8'(8'h10 + i));
        check_eq("fill_count", 32'(count), 32'd16);
        check_eq("fill_ready", 32'(ready), 32'd0);
        push_byte(8'hAA);
        check_eq("drop_count", 32'(count), 32'd16);
        full_pop_hits = 0;
        for (int i = 0; i < 80 && full_pop_hits == 0; i++) push_byte(8'hC3);
        check_eq("full_pop_timeout", 32'(full_pop_hits > 0), 32'd1);
        wait_idle();
        n_aa = 0;
        foreach (dec[k]) if (dec[k] == 8'hAA) n_aa++;
        check_eq("no_aa",      32'(n_aa),       32'd0);
        check_eq("fill_dec_n", 32'(dec.size()), 32'd17);
        if (dec.size() == 17) begin
            check_eq("fill_first", 32'(dec[0]),  32'h10);
            check_eq("fill_last",  32'(dec[16]), 32'h20);
        end

        // Reset during DATA bit 3 with bytes still queued.
        push_byte(8'hA1);
        push_byte(8'hB2);
        push_byte(8'hC3);
        for (int i = 0; i < 100 && !(pos >= 0 && pos / C == 4); i++) idle_tick();
        check_eq("mid_reached", 32'(pos >= 0 && pos / C == 4), 32'd1);
        tick(1'b1, 8'h77, 1'b1);
        check_eq("mid_rst_line",  32'(tx),    32'd1);
        check_eq("mid_rst_count", 32'(count), 32'd0);
        starts.delete();
        for (int i = 0; i < 60; i++) idle_tick();
        check_eq("mid_no_frames", 32'(starts.size()), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            tick($urandom_range(2) == 0, 8'($urandom), $urandom_range(399) == 0);
        end
        wait_idle();

        // Full-rate baud on the second instance.
        send_b = 1'b1;
        data_b = 8'h41;
        @(posedge clk); #1;
        send_b = 1'b0;
        check_eq("b_count", 32'(count_b), 32'd1);
        @(posedge clk); #1;
        check_eq("b_start", 32'(tx_b), 32'd0);
        for (int s = 1; s <= 10 * CB; s++) begin
            @(posedge clk); #1;
            if (s % CB == 0 || s % CB == CB - 1)
                check_eq("b_bit", 32'(tx_b), 32'((s / CB < 10) ? frame_bit(8'h41, s / CB) : 1'b1));
            if (s == 10 * CB - 1) check_eq("b_busy", 32'(idle_b), 32'd0);
            if (s == 10 * CB)     check_eq("b_idle", 32'(idle_b), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
